// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD script sequencer.
// Opcodes, controller register indices, FSM encoding.
package lcd_seq_pkg;

  localparam logic [1:0] OP_CMD  = 2'b00;
  localparam logic [1:0] OP_DATA = 2'b01;
  localparam logic [1:0] OP_DLY  = 2'b10;
  localparam logic [1:0] OP_END  = 2'b11;

  localparam int REG_SR   = 1;
  localparam int REG_ODR  = 2;
  localparam int REG_CMDR = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WR,
    S_WACK,
    S_PRD,
    S_RACK,
    S_DLY
  } state_t;

endpackage

// File: rtl/lcd_seq_up_master.sv
// up bus master leg: one-cycle wreq/rreq pulses,
// ack wait and ack timeout reported to the sequencer.
module lcd_seq_up_master
  import lcd_seq_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int ACK_MAX       = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_go_i,
  input  logic                     rd_go_i,
  input  logic                     wr_wait_i,
  input  logic                     rd_wait_i,
  input  logic [ADDRESS_WIDTH-1:0] waddr_i,
  input  logic [7:0]               wbyte_i,
  output logic                     ok_o,
  output logic                     timeout_o,
  output logic                     m_up_wreq,
  output logic [ADDRESS_WIDTH-1:0] m_up_waddr,
  output logic [31:0]              m_up_wdata,
  input  logic                     m_up_wack,
  output logic                     m_up_rreq,
  output logic [ADDRESS_WIDTH-1:0] m_up_raddr,
  input  logic                     m_up_rack
);

  localparam int CW = (ACK_MAX < 1) ? 1 : $clog2(ACK_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          ack;
  logic          waiting;

  assign waiting = wr_wait_i | rd_wait_i;
  assign ack     = (wr_wait_i & m_up_wack) | (rd_wait_i & m_up_rack);

  assign ok_o      = waiting & ack;
  assign timeout_o = waiting & ~ack & (cnt_q == CW'(ACK_MAX));

  // Requests exist only while the FSM sits in WR/PRD.
  assign m_up_wreq  = wr_go_i;
  assign m_up_waddr = wr_go_i ? waddr_i : '0;
  assign m_up_wdata = wr_go_i ? {24'd0, wbyte_i} : 32'd0;
  assign m_up_rreq  = rd_go_i;
  assign m_up_raddr = rd_go_i ? ADDRESS_WIDTH'(REG_SR) : '0;

  // Ack counter restarts on each request, runs while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_go_i || rd_go_i) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Ack counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_script_seq.sv
// Script-driven master replaying LCD command/data/delay
// entries into the SPI LCD controller over the up bus.
module lcd_script_seq
  import lcd_seq_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int SCRIPT_AW     = 8,
  parameter int DELAY_SCALE   = 1000,
  parameter int POLL_MAX      = 1023,
  parameter int ACK_MAX       = 255
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [SCRIPT_AW-1:0]     rom_addr,
  input  logic [15:0]              rom_data,
  output logic                     m_up_wreq,
  output logic [ADDRESS_WIDTH-1:0] m_up_waddr,
  output logic [31:0]              m_up_wdata,
  input  logic                     m_up_wack,
  output logic                     m_up_rreq,
  output logic [ADDRESS_WIDTH-1:0] m_up_raddr,
  input  logic [31:0]              m_up_rdata,
  input  logic                     m_up_rack
);

  localparam int PW = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);
  localparam int DW = 14 + $clog2(DELAY_SCALE + 1);

  state_t               state_q, state_d;
  logic [SCRIPT_AW-1:0] pc_q, pc_d;
  logic [7:0]           byte_q, byte_d;
  logic                 isdat_q, isdat_d;
  logic [PW-1:0]        poll_q, poll_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic                 error_q, error_d;
  logic                 done_q, done_d;

  logic                 mst_ok;
  logic                 mst_to;
  logic [1:0]           op;
  logic                 unused_rdata;

  assign op           = rom_data[15:14];
  assign unused_rdata = ^m_up_rdata[31:2];

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign rom_addr = pc_q;

  lcd_seq_up_master #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .ACK_MAX      (ACK_MAX)
  ) u_mst (
    .clk_i     (up_clk),
    .rst_ni    (up_rstn),
    .wr_go_i   (state_q == S_WR),
    .rd_go_i   (state_q == S_PRD),
    .wr_wait_i (state_q == S_WACK),
    .rd_wait_i (state_q == S_RACK),
    .waddr_i   (isdat_q ? ADDRESS_WIDTH'(REG_ODR)
                        : ADDRESS_WIDTH'(REG_CMDR)),
    .wbyte_i   (byte_q),
    .ok_o      (mst_ok),
    .timeout_o (mst_to),
    .m_up_wreq (m_up_wreq),
    .m_up_waddr(m_up_waddr),
    .m_up_wdata(m_up_wdata),
    .m_up_wack (m_up_wack),
    .m_up_rreq (m_up_rreq),
    .m_up_raddr(m_up_raddr),
    .m_up_rack (m_up_rack)
  );

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    byte_d  = byte_q;
    isdat_d = isdat_q;
    poll_d  = poll_q;
    dcnt_d  = dcnt_q;
    error_d = error_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          error_d = 1'b0;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        byte_d  = rom_data[7:0];
        isdat_d = (op == OP_DATA);
        case (op)
          OP_CMD, OP_DATA: state_d = S_WR;
          OP_DLY: begin
            if (rom_data[13:0] == 14'd0) begin
              state_d = S_FETCH;
              pc_d    = pc_q + 1'b1;
            end else begin
              state_d = S_DLY;
              dcnt_d  = DW'(rom_data[13:0]) * DW'(DELAY_SCALE);
            end
          end
          default: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        endcase
      end
      S_WR: begin
        poll_d  = '0;
        state_d = S_WACK;
      end
      S_WACK: begin
        if (mst_ok) begin
          state_d = S_PRD;
        end else if (mst_to) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end
      end
      S_PRD: begin
        state_d = S_RACK;
      end
      S_RACK: begin
        if (mst_ok) begin
          if (m_up_rdata[1:0] == 2'b00) begin
            state_d = S_FETCH;
            pc_d    = pc_q + 1'b1;
          end else if (poll_q == PW'(POLL_MAX)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end else begin
            poll_d  = poll_q + 1'b1;
            state_d = S_PRD;
          end
        end else if (mst_to) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end
      end
      S_DLY: begin
        dcnt_d = dcnt_q - 1'b1;
        if (dcnt_q == DW'(1)) begin
          state_d = S_FETCH;
          pc_d    = pc_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      byte_q  <= '0;
      isdat_q <= 1'b0;
      poll_q  <= '0;
      dcnt_q  <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      byte_q  <= byte_d;
      isdat_q <= isdat_d;
      poll_q  <= poll_d;
      dcnt_q  <= dcnt_d;
      error_q <= error_d;
      done_q  <= done_d;
    end
  end

endmodule
